// File: rtl/vnu_lut_pkg.sv
// Shared constants and FSM encoding for the decomposed variable-node LUT.
// Used by the loader and by the read-side address map.
// Package only: no timing or flow-control behaviour.
package vnu_lut_pkg;
    localparam int Y0_W        = 2;
    localparam int Y1_W        = 3;
    localparam int PAGE_ADDR_W = 5;
    localparam int DATA_W      = 3;
    localparam int PAGES       = 2 ** (Y0_W + Y1_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;
endpackage

// File: rtl/vn_page_cnt.sv
// Modulo-PAGES page counter with clear/enable, presenting the count split into y0/y1 fields.
// Latency: count updates one cycle after clr/en; the last flag is a combinational decode of the count.
// Backpressure: none; the owner gates en.
module vn_page_cnt #(
    parameter int Y0_W = 2,
    parameter int Y1_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [Y0_W-1:0] y0,
    output logic [Y1_W-1:0] y1,
    output logic            last
);
    localparam int CW = Y0_W + Y1_W;

    logic [CW-1:0] cnt;

    // Natural binary overflow gives the modulo-PAGES wrap.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign y0   = cnt[CW-1:Y1_W];
    assign y1   = cnt[Y1_W-1:0];
    assign last = (cnt == {CW{1'b1}});
endmodule

// File: rtl/vn_lut_loader.sv
// Streams LUT entries in page order into the idle bank, then swaps the active bank.
// Latency: write beat registered one cycle after accept; load_done one cycle after DONE.
// Backpressure: s_ready is a pure state decode (high only in LOAD); s_valid low stalls the pass.
module vn_lut_loader #(
    parameter int Y0_W        = vnu_lut_pkg::Y0_W,
    parameter int Y1_W        = vnu_lut_pkg::Y1_W,
    parameter int PAGE_ADDR_W = vnu_lut_pkg::PAGE_ADDR_W,
    parameter int DATA_W      = vnu_lut_pkg::DATA_W
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_abort,
    input  logic                   s_valid,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   s_ready,
    output logic                   wr_en,
    output logic                   wr_bank,
    output logic [PAGE_ADDR_W-1:0] wr_page_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   active_bank,
    output logic                   busy,
    output logic                   load_done
);
    import vnu_lut_pkg::*;

    state_t          state_q, state_d;
    logic            cnt_clr, cnt_en, cnt_last;
    logic            accept, swap, latch_tgt;
    logic            tgt_bank;
    logic [Y0_W-1:0] y0;
    logic [Y1_W-1:0] y1;

    vn_page_cnt #(
        .Y0_W (Y0_W),
        .Y1_W (Y1_W)
    ) u_page_cnt (
        .clk  (sys_clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .y0   (y0),
        .y1   (y1),
        .last (cnt_last)
    );

    always_ff @(posedge sys_clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        busy      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        accept    = 1'b0;
        swap      = 1'b0;
        latch_tgt = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    latch_tgt = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                // Abort wins over a coincident accept; the partial bank is simply never swapped in.
                if (load_abort) begin
                    state_d = IDLE;
                end else if (s_valid) begin
                    accept = 1'b1;
                    cnt_en = 1'b1;
                    if (cnt_last)
                        state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                swap    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            active_bank  <= 1'b0;
            tgt_bank     <= 1'b0;
            load_done    <= 1'b0;
            wr_en        <= 1'b0;
            wr_bank      <= 1'b0;
            wr_page_addr <= '0;
            wr_data      <= '0;
        end else begin
            load_done <= swap;
            wr_en     <= accept;
            if (swap)
                active_bank <= ~active_bank;
            if (latch_tgt)
                tgt_bank <= ~active_bank;
            if (accept) begin
                wr_bank      <= tgt_bank;
                wr_page_addr <= PAGE_ADDR_W'({y0, y1});
                wr_data      <= s_data;
            end
        end
    end
endmodule

// File: tb/tb_vn_lut_loader.sv
// Scoreboard bench for vn_lut_loader: stimulus pushes expected write beats and load_done
// events, a negedge monitor pops and compares whenever the DUT presents them.
module tb_vn_lut_loader;
    localparam int PAGES = 32;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       load_abort = 1'b0;
    logic       s_valid = 1'b0;
    logic [2:0] s_data = '0;
    logic       s_ready, wr_en, wr_bank, active_bank, busy, load_done;
    logic [4:0] wr_page_addr;
    logic [2:0] wr_data;

    vn_lut_loader dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_abort   (load_abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_page_addr (wr_page_addr),
        .wr_data      (wr_data),
        .active_bank  (active_bank),
        .busy         (busy),
        .load_done    (load_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { bit bank; int page; int data; } wr_t;
    typedef struct { int cyc; bit bank; } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    bit  model_active = 1'b0;
    wr_t mw;
    dn_t md;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got page %0d bank %0d, expected no write", wr_page_addr, wr_bank);
            end else begin
                mw = wq.pop_front();
                chk("wr_bank", 32'(wr_bank), 32'(mw.bank));
                // Page k is packed as y0 = k/2^Y1_W, y1 = k mod 2^Y1_W.
                chk("wr_page_addr", 32'(wr_page_addr), 32'((mw.page / 8) * 8 + (mw.page % 8)));
                chk("wr_data", 32'(wr_data), 32'(mw.data));
                if (mw.page == 13)
                    chk("addr_k13", 32'(wr_page_addr), 32'b01101);
            end
        end
        if (load_done === 1'b1) begin
            if (dq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_load_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                md = dq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(md.cyc));
                chk("active_bank_at_done", 32'(active_bank), 32'(md.bank));
            end
        end
    end

    task automatic run_pass(input bit stall, input int abort_at, input int rst_at,
                            input int mid_start_at, input bit seq_data, input bit start_at_done);
        int  t, k, c, nst;
        bit  bnk;
        wr_t w;
        dn_t d;
        t   = cyc;
        bnk = ~model_active;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("busy_in_load", 32'(busy), 32'd1);
        chk("s_ready_in_load", 32'(s_ready), 32'd1);
        k = 0; c = 0; nst = 0;
        while (k < PAGES) begin
            load_start = (k == mid_start_at);
            if (stall && (c % 3 == 2)) begin
                s_valid = 1'b0;
                nst++;
            end else begin
                s_valid = 1'b1;
                s_data  = seq_data ? 3'(k % 8) : 3'($urandom_range(0, 7));
                if (k == abort_at || k == rst_at) begin
                    load_abort = (k == abort_at);
                    rst        = (k == rst_at);
                    tick();
                    load_abort = 1'b0;
                    rst        = 1'b0;
                    s_valid    = 1'b0;
                    load_start = 1'b0;
                    chk("busy_after_cut", 32'(busy), 32'd0);
                    chk("s_ready_after_cut", 32'(s_ready), 32'd0);
                    if (k == rst_at) begin
                        model_active = 1'b0;
                        chk("rst_wr_en", 32'(wr_en), 32'd0);
                        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
                        chk("rst_wr_page_addr", 32'(wr_page_addr), 32'd0);
                        chk("rst_wr_data", 32'(wr_data), 32'd0);
                        chk("rst_load_done", 32'(load_done), 32'd0);
                    end
                    chk("active_bank_after_cut", 32'(active_bank), 32'(model_active));
                    repeat (5) tick();
                    chk("active_bank_still", 32'(active_bank), 32'(model_active));
                    chk("cut_writes_drained", 32'(wq.size()), 32'd0);
                    return;
                end
                w.bank = bnk; w.page = k; w.data = int'(s_data);
                wq.push_back(w);
                k++;
            end
            c++;
            tick();
        end
        load_start = start_at_done;
        s_valid    = 1'b0;
        d.cyc  = t + PAGES + 2 + nst;
        d.bank = ~model_active;
        dq.push_back(d);
        model_active = ~model_active;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 40 && dq.size() != 0; i++) tick();
        if (dq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no load_done, expected one at cycle %0d", dq[0].cyc);
            dq.delete();
        end
        chk("active_bank_after", 32'(active_bank), 32'(model_active));
        chk("busy_idle_after", 32'(busy), 32'd0);
        chk("s_ready_idle_after", 32'(s_ready), 32'd0);
        chk("writes_drained", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_active_bank", 32'(active_bank), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_s_ready", 32'(s_ready), 32'd0);
        chk("reset_load_done", 32'(load_done), 32'd0);
        chk("reset_wr_page_addr", 32'(wr_page_addr), 32'd0);
        rst = 1'b0;
        tick();
        run_pass(1'b0, -1, -1, -1, 1'b1, 1'b0);
        run_pass(1'b0, -1, -1, 5, 1'b0, 1'b1);
        run_pass(1'b1, -1, -1, -1, 1'b0, 1'b0);
        run_pass(1'b0, 10, -1, -1, 1'b0, 1'b0);
        run_pass(1'b0, -1, 20, -1, 1'b0, 1'b0);
        run_pass(1'b0, -1, -1, -1, 1'b0, 1'b0);
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vn_lut_loader.md
# vn_lut_loader

Sequential writer for the bank-interleaved, decomposed variable-node LUT of the 3-bit partial VNU. It takes a stream of LUT entries in page order, produces page addresses in the same `{y0, y1}` packing that the read-side address map decodes, and writes them into the idle one of two interleaving banks. When a full pass completes, it swaps the active bank. The next iteration's IB-LUT can therefore be preloaded while the decoder keeps reading the current one.

## Interface
Parameters:
- `Y0_W`, default 2: width of the y0 field.
- `Y1_W`, default 3: width of the y1 field.
- `PAGE_ADDR_W`, default 5: page address bus width; it is at least `Y0_W + Y1_W`.
- `DATA_W`, default 3: width of a LUT entry, which is the quantised output message.

Ports:
- `sys_clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `load_start`, in, 1: single-cycle request to begin a load pass.
- `load_abort`, in, 1: cancels the pass in progress.
- `s_valid`, in, 1: entry stream valid.
- `s_data`, in, `DATA_W`: LUT entry for the current page.
- `s_ready`, out, 1: loader accepts an entry this cycle.
- `wr_en`, out, 1: LUT write strobe.
- `wr_bank`, out, 1: target bank, always the idle bank.
- `wr_page_addr`, out, `PAGE_ADDR_W`: page address `{zero-pad, y0, y1}`.
- `wr_data`, out, `DATA_W`: entry to write.
- `active_bank`, out, 1: bank the decoder reads.
- `busy`, out, 1: a pass is in progress.
- `load_done`, out, 1: one-cycle pulse when a pass completes and the banks swap.

## Operation
- `PAGES = 2**(Y0_W+Y1_W)`, which is 32 by default.
- A page index `k` is written as `{y0, y1}`:
  - y0 = `k[Y0_W+Y1_W-1:Y1_W]`
  - y1 = `k[Y1_W-1:0]`
  - upper `wr_page_addr` bits are 0.
- The FSM has three states.
- **IDLE**:
  - `s_ready = 0` and `busy = 0`.
  - On `load_start`, latch `tgt_bank = ~active_bank`, clear the page counter to 0 and go to LOAD.
- **LOAD**:
  - `s_ready = 1` and `busy = 1`.
  - Each cycle with `s_valid & s_ready` is an accepted entry:
    - register `wr_en = 1`, `wr_page_addr = {0, cnt}`, `wr_data = s_data` and `wr_bank = tgt_bank`;
    - increment `cnt`.
  - The accept at `cnt == PAGES-1` moves the FSM to DONE, and `cnt` wraps to 0.
  - `s_valid = 0` is a stall: no write and no counter change.
- **DONE**, one cycle:
  - `s_ready = 0` and `busy = 1`.
  - Toggle `active_bank`, pulse `load_done` and return to IDLE.
- `load_abort` in LOAD has priority over an accept in the same cycle:
  - that entry is not written;
  - go to IDLE, with no swap and no `load_done`;
  - the already-written pages of the idle bank are don't-care.
- `load_abort` in IDLE or DONE is ignored.
- `load_start` outside IDLE is ignored; it is not queued.
- A `load_start` in the same cycle as the DONE→IDLE transition is ignored, so the earliest restart is the cycle after.
- `rst` has priority over everything and applies even mid-pass:
  - state goes to IDLE and `cnt` to 0;
  - `active_bank = 0`;
  - `wr_en = 0`, `wr_bank = 0`, `wr_page_addr = 0` and `wr_data = 0`;
  - `load_done = 0` and `busy = 0`.
- `wr_en` is 0 in every cycle without an accept. `wr_page_addr` and `wr_data` hold their last value, and the LUT ignores them while `wr_en = 0`.

## Timing
- Accept in cycle t gives the write beat (`wr_en`, `wr_bank`, `wr_page_addr`, `wr_data`) registered at t+1, so write latency is 1.
- `s_ready` is a combinational decode of the state register only; it never depends on `s_valid`.
- With back-to-back valid data a pass lasts 1 + `PAGES` + 1 cycles after `load_start`:
  - LOAD is entered at t+1;
  - the last accept happens at t+32;
  - DONE is at t+33;
  - `load_done` and the `active_bank` flip are both visible at t+34.
- The final write beat (page 31 at t+33) completes before `active_bank` changes, so the decoder never reads a partially written bank.
- `active_bank` changes only on the DONE cycle edge or on reset.

## Structure
- Shared package `vnu_lut_pkg` holds:
  - `Y0_W`, `Y1_W`, `PAGE_ADDR_W` and `DATA_W` as constants;
  - `PAGES`;
  - the state enum `{IDLE, LOAD, DONE}`.
- The read-side map uses the same package.
- One sub-module is natural: `vn_page_cnt`, a modulo-`PAGES` counter with clear/enable/wrap-flag, with y0/y1 field split outputs.
- The FSM, bank register and write-beat registers live in the top.

## Test plan
- **Full pass:** after reset (`active_bank = 0`), `load_start`, then 32 back-to-back entries with `s_data = k mod 8`.
  - 32 writes to bank 1, addresses 0..31, each `wr_data` matching its entry.
  - At k = 13, `wr_page_addr = 5'b01101` (y0 = 1, y1 = 5).
  - `load_done` at t+34 and `active_bank = 1`.
- **Stalls:** same as the full pass with `s_valid` low on every third cycle.
  - Identical write sequence with no address skipped or repeated.
  - `load_done` is delayed by exactly the number of stall cycles.
- **Abort:** assert `load_abort` together with the accept of page 10.
  - Only pages 0..9 are written.
  - No `load_done`, and `active_bank` stays unchanged.
  - `busy` falls the next cycle.
- **Second pass and ignored start:** run a second full pass after the first.
  - It targets bank 0, and `active_bank` returns to 0.
  - A `load_start` pulsed mid-LOAD has no effect.
- **Reset mid-pass:** assert `rst` at page 20 with `active_bank = 1`.
  - Next cycle: all outputs are 0, `active_bank = 0` and state is IDLE.
  - A following `load_start` targets bank 1 from page 0.
